seq_control_unit: RTL and testbench
===================================

# seq_control_unit

Multi-cycle, registered successor to the combinational control decoder. It accepts one instruction opcode per fetch handshake, steps it through a FETCH/DECODE/EXEC/MEM/WB state machine, and drives the ALU op, mux control lines and write strobes for exactly the cycles in which they are valid. It stalls on a data-memory ready handshake and resolves conditional branches from the ALU flags. It sits between the instruction fetch stage and the ALU/register/data-memory datapath.

## Interface
- OP_W, 4: opcode field width; `op_in` is OP_W+1 bits (opcode plus BRX bit).
- ALU_W, 4: width of `opOut`.
- CL_W, 6: width of `cLines`.
- MEM_TIMEOUT, 15: maximum MEM-state cycles before abort; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_valid  in  1  fetch stage presents `op_in`.
- instr_ready  out  1  unit accepts `op_in` this cycle.
- op_in  in  OP_W+1  [OP_W:1] opcode, [0] BRX (1=branch-on-N, 0=branch-on-Z).
- flag_z, flag_n  in  1  ALU zero/negative flags, sampled in EXEC.
- mem_ready  in  1  data memory completes the access this cycle.
- opOut  out  ALU_W  ALU function.
- cLines  out  CL_W  datapath mux controls (instruction-set `*_C` codes).
- regWrite, memWrite, memRead, WEtemp, WEinOut  out  1  write/read strobes.
- pcLine  out  1  1 = PC+1, 0 = load branch target.
- pc_en  out  1  one-cycle PC update strike.
- busy  out  1  state is not FETCH.
- err  out  1  sticky memory-timeout flag, cleared only by rst.

## Operation
- Decode per opcode uses the shared instruction-set encodings: ALU ops (ADD, SUB, NAND, SHL, SHR, MOV) drive opOut = opcode; all others drive opOut = NOOP. The cLines value is the matching `*_C` code.
- Unknown opcodes decode as NOOP: no strobes, PC+1.
- All outputs are registered. Outputs come from the latched opcode, never directly from `op_in`.
- FETCH: instr_ready=1. On instr_valid, latch op_in and go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): drive opOut/cLines; go to EXEC.
- EXEC (1 cycle): opOut/cLines held.
  - LOAD/STORE go to MEM.
  - BR_Z/BR_N: branch taken if (BRX ? flag_n : flag_z). pcLine=0 if taken, else 1; go to WB.
  - BR/RETURN/BR_SUB: pcLine=1; go to WB.
  - Everything else goes to WB.
- MEM: memRead=1 (LOAD) or memWrite=1 (STORE), held continuously. A wait counter starts at 0 on entry and increments each cycle.
  - mem_ready=1: go to WB.
  - Counter reaches MEM_TIMEOUT-1 without mem_ready: set err, drop strobes, pulse pc_en with pcLine=1, return to FETCH. No regWrite is issued.
- WB (1 cycle): pc_en=1.
  - regWrite=1 for ADD/SUB/NAND/SHL/SHR/MOV/IN/LOAD/LOADIMM.
  - WEinOut=1 for OUT; WEtemp=1 for BR_SUB.
  - Then go to FETCH; all strobes return to 0.
- At most one of regWrite/WEinOut/WEtemp is high in any cycle. memRead and memWrite are never both high.

## Timing
- Reset values: state=FETCH, opOut=NOOP, cLines=NOOP_C, all strobes 0, pcLine=1, pc_en=0, busy=0, err=0.
- instr_ready is 0 during the rst cycle and 1 in the first cycle after.
- rst mid-instruction: at the next edge, abandon the instruction, return all outputs to reset values, and drop any MEM strobe immediately.
- Latency from accept edge to pc_en:
  - non-memory instructions: 3 cycles (DECODE, EXEC, WB);
  - memory instructions: 3 + N cycles, where N ≥ 1 is the number of MEM cycles including the mem_ready cycle.
- mem_ready outside MEM is ignored.
- instr_valid outside FETCH is ignored; the fetch stage must hold op_in until accepted.
- Back-to-back throughput: a new instruction can be accepted in the cycle after WB.
- Flags are sampled only at the EXEC edge. Flag changes in other cycles have no effect.
- The timeout counter width is ceil(log2(MEM_TIMEOUT+1)) and never wraps: it stops at MEM_TIMEOUT-1.

## Test plan
- ADD accepted at cycle 0 → opOut=ADD from cycle 1; regWrite and pc_en high only in cycle 3; pcLine=1; then instr_ready=1 in cycle 4.
- LOAD with mem_ready asserted on the 3rd MEM cycle → memRead high for exactly 3 cycles; regWrite and pc_en in the following cycle; total 6 cycles to pc_en.
- BR_N (BRX=1): flag_n=1 in EXEC → pcLine=0 in WB. Repeat with flag_n=0, flag_z=1 → pcLine=1. BR_Z with flag_z=1 → pcLine=0.
- STORE with mem_ready held 0, MEM_TIMEOUT=15 → memWrite high for 15 cycles, err=1 after that, no regWrite, pc_en pulses with pcLine=1, return to FETCH; err stays 1 across the next ADD.
- rst asserted in the 2nd MEM cycle of a LOAD → next cycle memRead=0, state FETCH, err=0, instr_ready=1 one cycle after rst deasserts.
- Sequence OUT, BR_SUB, unknown opcode, instr_valid toggling while busy → WEinOut in OUT's WB only; WEtemp in BR_SUB's WB only; unknown opcode gives no strobes and pc_en with pcLine=1; no extra instructions accepted.

Source files
------------

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: sequences each accepted opcode through FETCH/DECODE/EXEC/MEM/WB
// and drives registered ALU op, datapath mux codes and write strobes for the valid cycles only.
module seq_control_unit #(
   parameter int OP_W        = 4,
   parameter int ALU_W       = 4,
   parameter int CL_W        = 6,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [OP_W:0]    op_in,
   input  logic             flag_z,
   input  logic             flag_n,
   input  logic             mem_ready,
   output logic [ALU_W-1:0] opOut,
   output logic [CL_W-1:0]  cLines,
   output logic             regWrite,
   output logic             memWrite,
   output logic             memRead,
   output logic             WEtemp,
   output logic             WEinOut,
   output logic             pcLine,
   output logic             pc_en,
   output logic             busy,
   output logic             err
);

   localparam logic [OP_W-1:0] OPC_NOOP    = OP_W'(0);
   localparam logic [OP_W-1:0] OPC_ADD     = OP_W'(1);
   localparam logic [OP_W-1:0] OPC_SUB     = OP_W'(2);
   localparam logic [OP_W-1:0] OPC_NAND    = OP_W'(3);
   localparam logic [OP_W-1:0] OPC_SHL     = OP_W'(4);
   localparam logic [OP_W-1:0] OPC_SHR     = OP_W'(5);
   localparam logic [OP_W-1:0] OPC_MOV     = OP_W'(6);
   localparam logic [OP_W-1:0] OPC_IN      = OP_W'(7);
   localparam logic [OP_W-1:0] OPC_OUT     = OP_W'(8);
   localparam logic [OP_W-1:0] OPC_LOAD    = OP_W'(9);
   localparam logic [OP_W-1:0] OPC_STORE   = OP_W'(10);
   localparam logic [OP_W-1:0] OPC_LOADIMM = OP_W'(11);
   localparam logic [OP_W-1:0] OPC_BR      = OP_W'(12);
   localparam logic [OP_W-1:0] OPC_BRC     = OP_W'(13);
   localparam logic [OP_W-1:0] OPC_RETURN  = OP_W'(14);
   localparam logic [OP_W-1:0] OPC_BR_SUB  = OP_W'(15);

   localparam logic [CL_W-1:0] NOOP_C = CL_W'(6'h00);

   localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   function automatic logic [ALU_W-1:0] alu_of(input logic [OP_W-1:0] opc);
      case (opc)
         OPC_ADD, OPC_SUB, OPC_NAND, OPC_SHL, OPC_SHR, OPC_MOV: alu_of = ALU_W'(opc);
         default:                                               alu_of = ALU_W'(OPC_NOOP);
      endcase
   endfunction

   function automatic logic [CL_W-1:0] cl_of(input logic [OP_W-1:0] opc);
      case (opc)
         OPC_ADD:     cl_of = CL_W'(6'h01);
         OPC_SUB:     cl_of = CL_W'(6'h02);
         OPC_NAND:    cl_of = CL_W'(6'h03);
         OPC_SHL:     cl_of = CL_W'(6'h04);
         OPC_SHR:     cl_of = CL_W'(6'h05);
         OPC_MOV:     cl_of = CL_W'(6'h06);
         OPC_IN:      cl_of = CL_W'(6'h08);
         OPC_OUT:     cl_of = CL_W'(6'h10);
         OPC_LOAD:    cl_of = CL_W'(6'h12);
         OPC_STORE:   cl_of = CL_W'(6'h14);
         OPC_LOADIMM: cl_of = CL_W'(6'h09);
         OPC_BR:      cl_of = CL_W'(6'h20);
         OPC_BRC:     cl_of = CL_W'(6'h21);
         OPC_RETURN:  cl_of = CL_W'(6'h22);
         OPC_BR_SUB:  cl_of = CL_W'(6'h24);
         default:     cl_of = NOOP_C;
      endcase
   endfunction

   function automatic logic writes_reg(input logic [OP_W-1:0] opc);
      case (opc)
         OPC_ADD, OPC_SUB, OPC_NAND, OPC_SHL, OPC_SHR, OPC_MOV,
         OPC_IN, OPC_LOAD, OPC_LOADIMM: writes_reg = 1'b1;
         default:                       writes_reg = 1'b0;
      endcase
   endfunction

   state_t           state, state_d;
   logic [OP_W-1:0]  opc_q, opc_d;
   logic             brx_q, brx_d;
   logic [CNT_W-1:0] cnt, cnt_d;

   logic             instr_ready_d, busy_d, err_d, pc_en_d, pc_line_d;
   logic             reg_write_d, mem_write_d, mem_read_d, we_temp_d, we_in_out_d;
   logic [ALU_W-1:0] op_out_d;
   logic [CL_W-1:0]  c_lines_d;
   logic             in_flight;

   // Every output is registered from the next state, so it is valid in the same cycle the state is.
   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d   = state;
      opc_d     = opc_q;
      brx_d     = brx_q;
      cnt_d     = cnt;
      err_d     = err;
      pc_en_d   = 1'b0;
      pc_line_d = 1'b1;

      case (state)
         S_FETCH: begin
            if (instr_ready && instr_valid) begin
               opc_d   = op_in[OP_W:1];
               brx_d   = op_in[0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            cnt_d   = '0;
            state_d = (opc_q == OPC_LOAD || opc_q == OPC_STORE) ? S_MEM : S_WB;
            if (opc_q == OPC_BRC) pc_line_d = ~(brx_q ? flag_n : flag_z);
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = S_WB;
            end else if (cnt == CNT_LAST) begin
               // Abort: skip WB, step the PC past the faulting instruction.
               state_d = S_FETCH;
               err_d   = 1'b1;
               pc_en_d = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase

      in_flight     = (state_d != S_FETCH);
      instr_ready_d = ~in_flight;
      busy_d        = in_flight;
      op_out_d      = in_flight ? alu_of(opc_d) : ALU_W'(OPC_NOOP);
      c_lines_d     = in_flight ? cl_of(opc_d)  : NOOP_C;
      mem_read_d    = (state_d == S_MEM) && (opc_d == OPC_LOAD);
      mem_write_d   = (state_d == S_MEM) && (opc_d == OPC_STORE);
      reg_write_d   = (state_d == S_WB)  && writes_reg(opc_d);
      we_in_out_d   = (state_d == S_WB)  && (opc_d == OPC_OUT);
      we_temp_d     = (state_d == S_WB)  && (opc_d == OPC_BR_SUB);
      if (state_d == S_WB) pc_en_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state       <= S_FETCH;
         opc_q       <= OPC_NOOP;
         brx_q       <= 1'b0;
         cnt         <= '0;
         instr_ready <= 1'b0;
         opOut       <= ALU_W'(OPC_NOOP);
         cLines      <= NOOP_C;
         regWrite    <= 1'b0;
         memWrite    <= 1'b0;
         memRead     <= 1'b0;
         WEtemp      <= 1'b0;
         WEinOut     <= 1'b0;
         pcLine      <= 1'b1;
         pc_en       <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_d;
         opc_q       <= opc_d;
         brx_q       <= brx_d;
         cnt         <= cnt_d;
         instr_ready <= instr_ready_d;
         opOut       <= op_out_d;
         cLines      <= c_lines_d;
         regWrite    <= reg_write_d;
         memWrite    <= mem_write_d;
         memRead     <= mem_read_d;
         WEtemp      <= we_temp_d;
         WEinOut     <= we_in_out_d;
         pcLine      <= pc_line_d;
         pc_en       <= pc_en_d;
         busy        <= busy_d;
         err         <= err_d;
      end
   end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: per-cycle trace model, table of directed vectors,
// reset-in-MEM sequence and randomized instruction stream.
module tb_seq_control_unit;

   localparam int TO = 15;

   localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, MOV = 4'd6, IN = 4'd7, OUT = 4'd8,
                          LOAD = 4'd9, STORE = 4'd10, LOADIMM = 4'd11, BR = 4'd12,
                          BRC = 4'd13, RET = 4'd14, BR_SUB = 4'd15, UNK = 4'd0;

   localparam logic [5:0] CL_TAB [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08,
                                          6'h10, 6'h12, 6'h14, 6'h09, 6'h20, 6'h21, 6'h22, 6'h24};

   logic       clk, rst, instr_valid, instr_ready, flag_z, flag_n, mem_ready;
   logic [4:0] op_in;
   logic [3:0] opOut;
   logic [5:0] cLines;
   logic       regWrite, memWrite, memRead, WEtemp, WEinOut, pcLine, pc_en, busy, err;

   seq_control_unit #(.OP_W(4), .ALU_W(4), .CL_W(6), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op_in(op_in), .flag_z(flag_z), .flag_n(flag_n), .mem_ready(mem_ready),
      .opOut(opOut), .cLines(cLines), .regWrite(regWrite), .memWrite(memWrite),
      .memRead(memRead), .WEtemp(WEtemp), .WEinOut(WEinOut), .pcLine(pcLine),
      .pc_en(pc_en), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_total = 0;
   int   n_pass  = 0;
   logic err_m   = 1'b0;

   logic [19:0] obs;
   assign obs = {instr_ready, opOut, cLines, regWrite, memWrite, memRead,
                 WEtemp, WEinOut, pcLine, pc_en, busy, err};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [19:0] rec(input logic rdy, input logic [3:0] alu, input logic [5:0] cl,
                                       input logic rw, input logic mw, input logic mr,
                                       input logic wet, input logic weio, input logic pcl,
                                       input logic pce, input logic bsy, input logic e);
      return {rdy, alu, cl, rw, mw, mr, wet, weio, pcl, pce, bsy, e};
   endfunction

   // One instruction, from its accept cycle to its pc_en cycle, checked cycle by cycle.
   // mem_lat: MEM cycle (1-based) carrying mem_ready; 0 or beyond TO means never.
   task automatic run_instr(input logic [3:0] op, input logic brx, input logic fz, input logic fn,
                            input int mem_lat, output int lat, output logic [2:0] wb_str,
                            output logic wb_pcl, output int mem_cyc, output logic [3:0] dec_alu,
                            output logic [5:0] dec_cl, output logic wb_err);
      logic [19:0] exp_q[$];
      logic [3:0]  alu;
      logic        is_mem, aborted, rw, taken;
      int          n_mem;

      alu     = (op >= 4'd1 && op <= 4'd6) ? op : 4'd0;
      is_mem  = (op == LOAD || op == STORE);
      aborted = is_mem && !(mem_lat >= 1 && mem_lat <= TO);
      n_mem   = !is_mem ? 0 : (aborted ? TO : mem_lat);
      rw      = (op >= 4'd1 && op <= 4'd7) || op == LOAD || op == LOADIMM;
      taken   = (op == BRC) && (brx ? fn : fz);

      exp_q.push_back(rec(1, 0, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0, err_m));
      repeat (2) exp_q.push_back(rec(0, alu, CL_TAB[op], 0, 0, 0, 0, 0, 1, 0, 1, err_m));
      for (int k = 0; k < n_mem; k++)
         exp_q.push_back(rec(0, alu, CL_TAB[op], 0, op == STORE, op == LOAD, 0, 0, 1, 0, 1, err_m));
      if (aborted) begin
         err_m = 1'b1;
         exp_q.push_back(rec(1, 0, 6'h00, 0, 0, 0, 0, 0, 1, 1, 0, 1));
      end else begin
         exp_q.push_back(rec(0, alu, CL_TAB[op], rw, 0, 0, op == BR_SUB, op == OUT, !taken, 1, 1, err_m));
      end

      lat = -1; wb_str = 3'b000; wb_pcl = 1'bx; mem_cyc = 0; dec_alu = 'x; dec_cl = 'x; wb_err = 1'bx;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check($sformatf("op%0d cyc%0d", op, i), 32'(obs), 32'(exp_q[i]));
         if (i == 1) begin dec_alu = opOut; dec_cl = cLines; end
         if (memRead || memWrite) mem_cyc++;
         if (pc_en && lat < 0) begin
            lat = i; wb_str = {regWrite, WEinOut, WEtemp}; wb_pcl = pcLine; wb_err = err;
         end
         if (i == 0) begin
            instr_valid = 1'b1;
            op_in       = {op, brx};
         end else if (aborted && i == exp_q.size() - 1) begin
            instr_valid = 1'b0;
         end else begin
            instr_valid = 1'($urandom);
            op_in       = 5'($urandom);
         end
         if (i == 2) begin flag_z = fz; flag_n = fn; end
         else        begin flag_z = 1'($urandom); flag_n = 1'($urandom); end
         if (is_mem && i >= 3 && i < 3 + n_mem) mem_ready = ((i - 2) == mem_lat);
         else                                   mem_ready = 1'($urandom);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle", 32'(obs), 32'(rec(1, 0, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0, err_m)));
         instr_valid = 1'b0;
         op_in       = 5'($urandom);
         mem_ready   = 1'($urandom);
      end
   endtask

   typedef struct {
      logic [3:0] op;
      logic       brx, fz, fn;
      int         mem_lat;
      logic [3:0] e_alu;
      logic [5:0] e_cl;
      logic [2:0] e_str;   // {regWrite, WEinOut, WEtemp} at pc_en
      logic       e_pcl;
      int         e_lat;
      int         e_mem;
      logic       e_err;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int         lat, mcyc;
      logic [2:0] str;
      logic       pcl, werr;
      logic [3:0] dalu;
      logic [5:0] dcl;

      vecs[0]  = '{ADD,     0, 0, 0, 0, 4'd1, 6'h01, 3'b100, 1, 3,  0,  0};
      vecs[1]  = '{LOAD,    0, 0, 0, 3, 4'd0, 6'h12, 3'b100, 1, 6,  3,  0};
      vecs[2]  = '{BRC,     1, 0, 1, 0, 4'd0, 6'h21, 3'b000, 0, 3,  0,  0};
      vecs[3]  = '{BRC,     1, 1, 0, 0, 4'd0, 6'h21, 3'b000, 1, 3,  0,  0};
      vecs[4]  = '{BRC,     0, 1, 0, 0, 4'd0, 6'h21, 3'b000, 0, 3,  0,  0};
      vecs[5]  = '{BRC,     0, 0, 1, 0, 4'd0, 6'h21, 3'b000, 1, 3,  0,  0};
      vecs[6]  = '{OUT,     0, 0, 0, 0, 4'd0, 6'h10, 3'b010, 1, 3,  0,  0};
      vecs[7]  = '{BR_SUB,  0, 0, 0, 0, 4'd0, 6'h24, 3'b001, 1, 3,  0,  0};
      vecs[8]  = '{UNK,     0, 0, 0, 0, 4'd0, 6'h00, 3'b000, 1, 3,  0,  0};
      vecs[9]  = '{STORE,   0, 0, 0, 1, 4'd0, 6'h14, 3'b000, 1, 4,  1,  0};
      vecs[10] = '{STORE,   0, 0, 0, 0, 4'd0, 6'h14, 3'b000, 1, 18, 15, 1};
      vecs[11] = '{ADD,     0, 0, 0, 0, 4'd1, 6'h01, 3'b100, 1, 3,  0,  1};
      vecs[12] = '{SUB,     0, 1, 1, 0, 4'd2, 6'h02, 3'b100, 1, 3,  0,  1};
      vecs[13] = '{LOADIMM, 0, 0, 0, 0, 4'd0, 6'h09, 3'b100, 1, 3,  0,  1};
      vecs[14] = '{RET,     0, 0, 0, 0, 4'd0, 6'h22, 3'b000, 1, 3,  0,  1};
      vecs[15] = '{MOV,     1, 1, 1, 0, 4'd6, 6'h06, 3'b100, 1, 3,  0,  1};

      rst = 1'b1; instr_valid = 1'b0; op_in = '0; flag_z = 1'b0; flag_n = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset state", 32'(obs), 32'(rec(0, 0, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
      rst = 1'b0;
      idle(1);

      foreach (vecs[v]) begin
         run_instr(vecs[v].op, vecs[v].brx, vecs[v].fz, vecs[v].fn, vecs[v].mem_lat,
                   lat, str, pcl, mcyc, dalu, dcl, werr);
         check($sformatf("vec%0d latency", v),   32'(lat),  32'(vecs[v].e_lat));
         check($sformatf("vec%0d strobes", v),   32'(str),  32'(vecs[v].e_str));
         check($sformatf("vec%0d pcLine", v),    32'(pcl),  32'(vecs[v].e_pcl));
         check($sformatf("vec%0d mem cycles", v), 32'(mcyc), 32'(vecs[v].e_mem));
         check($sformatf("vec%0d opOut", v),     32'(dalu), 32'(vecs[v].e_alu));
         check($sformatf("vec%0d cLines", v),    32'(dcl),  32'(vecs[v].e_cl));
         check($sformatf("vec%0d err", v),       32'(werr), 32'(vecs[v].e_err));
      end

      // Reset during the second MEM cycle of a LOAD.
      @(negedge clk);
      check("rstmem accept ready", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1; op_in = {LOAD, 1'b0}; mem_ready = 1'b0;
      @(negedge clk); instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstmem mem1 memRead", 32'(memRead), 32'd1);
      @(negedge clk);
      check("rstmem mem2 memRead", 32'(memRead), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rstmem after rst", 32'(obs), 32'(rec(0, 0, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
      rst = 1'b0; err_m = 1'b0;
      idle(2);

      // Randomized instruction stream against the trace model.
      for (int t = 0; t < 60; t++) begin
         logic [3:0] rop;
         int         rlat;
         rop  = 4'($urandom_range(0, 15));
         if (t % 3 == 0) rop = ($urandom_range(0, 1) == 1) ? LOAD : STORE;
         rlat = $urandom_range(0, 5);
         run_instr(rop, 1'($urandom), 1'($urandom), 1'($urandom), rlat,
                   lat, str, pcl, mcyc, dalu, dcl, werr);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
